latch_capture_reader: RTL
=========================

// Module: latch_capture_reader
// PURPOSE
//  Reader for the transparent D-latch storage used across the design.
//  - Watches the latch enable (le, asynchronous to clk) and the latch q outputs (d_in).
//  - When le closes (falls), d_in is frozen. The block captures it into the clk domain.
//  - Captured words are buffered in a 2-entry FIFO and presented on a valid/ready stream.
//  - Sits between latch-held data and synchronous consumers.
// PARAMETERS
//  W            8   data width of d_in / out_data
//  SYNC_STAGES  2   flops in le synchronizer chain (>=2)
//  CNT_W        8   width of cap_count (used only when CAPTURE_COUNT_EN is defined)
// PORTS
//  clk        in   1     single clock, all state on rising edge
//  rst        in   1     asynchronous, active-low reset (0 = reset asserted)
//  le         in   1     latch enable, async to clk; 1 = latch transparent, 0 = latch holding
//  d_in       in   W     latch q bus; stable from le fall until SYNC_STAGES+2 clk edges later
//  out_ready  in   1     consumer ready
//  clr_ovr    in   1     synchronous clear of the overrun flag
//  out_valid  out  1     FIFO head valid
//  out_data   out  W     FIFO head data
//  overrun    out  1     sticky flag: a capture was dropped because the FIFO was full
//  cap_count  out  CNT_W accepted-capture count (only with CAPTURE_COUNT_EN)
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - sync chain, le_d, FIFO pointers/count, overrun and cap_count all clear to 0.
//   - out_valid=0, out_data=0.
//  Synchronizer:
//   - le passes through SYNC_STAGES flops; le_s is the last stage; le_d is le_s delayed one cycle.
//   - cap_ev = le_d & ~le_s (closing edge). Only falling edges capture; rising edges are ignored.
//  Capture:
//   - On a cycle with cap_ev, d_in is written into the FIFO at the next edge.
//   - Latency: le falls -> out_valid=1 after SYNC_STAGES+1 rising edges (exact for stimulus
//     changed mid-cycle; +1 tolerance for metastable resolution).
//  FIFO: 2 entries; wr_ptr/rd_ptr are 1 bit; count is 0..2.
//   - push = cap_ev & (count<2 | pop).
//   - pop  = out_valid & out_ready.
//   - out_valid = (count!=0); out_data = mem[rd_ptr], registered storage, no bypass.
//   - Full (count=2), cap_ev, and pop in the same cycle: both happen, count stays 2.
//   - Full, cap_ev, no pop: word dropped, overrun<=1.
//   - Empty: pop is impossible (out_valid=0).
//   - out_data/out_valid must stay stable while out_valid=1 and out_ready=0.
//   - Pointers wrap 1->0.
//  Overrun:
//   - Sticky; cleared by clr_ovr=1.
//   - clr_ovr and a new drop in the same cycle: set wins (overrun stays 1).
//  Reset mid-operation:
//   - FIFO contents are discarded.
//   - If le is high at reset release, the chain fills from 0. A later le fall is captured
//     normally. No spurious capture occurs, because le_d starts at 0.
// CONFIGURATION
//  CAPTURE_COUNT_EN defined:
//   - cap_count increments by 1 on every accepted push and wraps at 2**CNT_W.
//   - Dropped captures do not count. Reset value is 0.
//  CAPTURE_COUNT_EN undefined:
//   - cap_count port and counter logic are absent.
//   - All other behaviour is identical.
// STRUCTURE
//  Package latch_rd_pkg:
//   - FIFO_DEPTH=2, PTR_W=1, default SYNC_STAGES and W.
//  Sub-module le_sync:
//   - Parameterized SYNC_STAGES flop chain plus le_d register.
//   - Outputs le_s and cap_ev, with async active-low reset.
//  Top level holds the FIFO, overrun flag and optional counter.
// TESTING
//  1. Reset: rst=0 with le=1, d_in=8'hFF -> out_valid=0, out_data=0, overrun=0.
//     Release rst; no capture while le stays 1.
//  2. Single capture: d_in=8'hA5, le 1->0 mid-cycle, out_ready=0 -> out_valid=1 and
//     out_data=8'hA5 exactly 3 edges later (SYNC_STAGES=2). Data holds until out_ready=1.
//  3. Fill and overrun, out_ready=0: capture 8'h11, 8'h22, 8'h33 -> out_data=8'h11,
//     overrun=1. Drain gives 8'h11 then 8'h22, then out_valid=0.
//  4. Full with pop in the same cycle as cap_ev (8'h44) -> no overrun, count stays 2.
//     Order after drain is 8'h22, 8'h44.
//  5. Overrun clear: clr_ovr=1 for one cycle -> overrun=0.
//     clr_ovr coinciding with a drop -> overrun stays 1.
//  6. CAPTURE_COUNT_EN: 3 accepted and 1 dropped capture -> cap_count=3.
//     Reset mid-stream -> cap_count=0, out_valid=0.

Source files
------------

// File: rtl/latch_rd_pkg.sv
// Shared constants for the latch capture reader.
// FIFO geometry and default widths live here.
package latch_rd_pkg;

  localparam int FIFO_DEPTH      = 2;
  localparam int PTR_W           = 1;
  localparam int CNT_BITS        = $clog2(FIFO_DEPTH + 1);
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_W           = 8;

  typedef logic [PTR_W-1:0]    ptr_t;
  typedef logic [CNT_BITS-1:0] fcnt_t;

endpackage

// File: rtl/latch_capture_reader_le_sync.sv
// Brings the asynchronous latch enable into clk
// and flags its closing (falling) edge as cap_ev.
module le_sync
  import latch_rd_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic le,
  output logic le_s,
  output logic cap_ev
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   le_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
      le_d  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], le};
      le_d  <= le_s;
    end
  end

  assign le_s   = chain[SYNC_STAGES-1];
  // le_d clears on reset, so le high at release never fakes an edge
  assign cap_ev = le_d & ~le_s;

endmodule

// File: rtl/latch_capture_reader.sv
// Captures latch data on le close into a 2-deep valid/ready FIFO.
// Optional accepted-capture counter under CAPTURE_COUNT_EN.
module latch_capture_reader
  import latch_rd_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef CAPTURE_COUNT_EN
  , parameter int CNT_W     = 8
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         le,
  input  logic [W-1:0] d_in,
  input  logic         out_ready,
  input  logic         clr_ovr,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         overrun
`ifdef CAPTURE_COUNT_EN
  , output logic [CNT_W-1:0] cap_count
`endif
);

  logic         le_s;
  logic         cap_ev;
  logic [W-1:0] mem [FIFO_DEPTH];
  ptr_t         wr_ptr;
  ptr_t         rd_ptr;
  fcnt_t        count;
  logic         full;
  logic         push;
  logic         pop;
  logic         drop;

  le_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .le    (le),
    .le_s  (le_s),
    .cap_ev(cap_ev)
  );

  assign full      = (count == fcnt_t'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  // a pop frees the slot the same cycle, so a full FIFO still accepts
  assign push      = cap_ev & (~full | pop);
  assign drop      = cap_ev & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= d_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push & ~pop: count <= count + 1'b1;
        pop & ~push: count <= count - 1'b1;
        default:     count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

`ifdef CAPTURE_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cap_count <= '0;
    else if (push) cap_count <= cap_count + 1'b1;
  end
`endif

endmodule
